// File: rtl/csa_pkg.sv
// Shared types and constant helpers for the carry-save accumulator.
package csa_pkg;

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// Operand input stream and result output stream of the carry-save accumulator.
interface csa_accumulator_if #(
  parameter int N = 256,
  parameter int A = 260
);

  // Both streams use valid/ready: a beat transfers on a rising clk edge where
  // valid and ready are both high; the source holds valid/payload until then.
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [A-1:0] out_data;
  logic         out_ovf;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );

endinterface

// File: rtl/csa_3to2.sv
// Width-parametrised 3:2 compressor; the carry vector is pre-shifted and its
// top bit dropped so the redundant pair stays modulo 2^W.
module csa_3to2 #(
  parameter int W = 260
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] d,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  logic [W-1:0] maj;

  assign s   = a ^ b ^ d;
  assign maj = (a & b) | (a & d) | (b & d);
  assign c   = {maj[W-2:0], 1'b0};

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator: carry-save absorb, chunked ripple
// resolve, then a registered valid/ready result with a sticky overflow flag.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int N = 256,
  parameter int G = 4,
  parameter int K = 65
) (
  input  logic              clk,
  input  logic              rst_n,
  csa_accumulator_if.slave  bus,
  output state_t            dbg_state
);

  localparam int A      = N + G;
  localparam int NCHUNK = A / K;
  localparam int IW     = (clog2(NCHUNK) < 1) ? 1 : clog2(NCHUNK);
  localparam logic [G:0]    CAP     = (G + 1)'(2 ** G);
  localparam logic [G:0]    CNT_MAX = (G + 1)'(2 ** G + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  generate
    if (A % K != 0) begin : g_bad_chunk
      $error("csa_accumulator: N+G must be a multiple of K");
    end
  endgenerate

  state_t        state_q, state_d;
  logic [A-1:0]  s_q, c_q, r_q;
  logic [A-1:0]  s_nx, c_nx, x;
  logic [G:0]    cnt_q;
  logic [IW-1:0] idx_q;
  logic          cy_q;
  logic          out_valid_q;
  logic          out_ovf_q;
  logic          acc_ready;
  logic          accept;
  logic          last_chunk;
  logic [K:0]    chunk_sum;

  assign x = {{G{1'b0}}, bus.in_data};

  csa_3to2 #(.W(A)) u_csa (
    .a (s_q),
    .b (c_q),
    .d (x),
    .s (s_nx),
    .c (c_nx)
  );

  assign accept     = bus.in_valid & acc_ready;
  assign last_chunk = (idx_q == LAST_IDX);
  assign chunk_sum  = {1'b0, s_q[idx_q*K +: K]} + {1'b0, c_q[idx_q*K +: K]}
                    + {{K{1'b0}}, cy_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ACC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (accept && bus.in_last) state_d = RESOLVE;
      RESOLVE: if (last_chunk)            state_d = OUT;
      OUT:     if (bus.out_ready)         state_d = ACC;
      default:                            state_d = ACC;
    endcase
  end

  always_comb begin
    acc_ready = 1'b0;
    if (state_q == ACC) acc_ready = 1'b1;
  end

  // Datapath; the result flags are loaded on the final resolve edge so they
  // become valid together with the OUT state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      c_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      cy_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept) begin
            s_q <= s_nx;
            c_q <= c_nx;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + (G + 1)'(1);
            if (bus.in_last) begin
              idx_q <= '0;
              cy_q  <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          r_q[idx_q*K +: K] <= chunk_sum[K-1:0];
          cy_q              <= chunk_sum[K];
          idx_q             <= idx_q + IW'(1);
          if (last_chunk) begin
            idx_q       <= '0;
            cy_q        <= 1'b0;
            out_valid_q <= 1'b1;
            out_ovf_q   <= (cnt_q > CAP);
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            s_q         <= '0;
            c_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_ovf_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = acc_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = r_q;
  assign bus.out_ovf   = out_ovf_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed bench for csa_accumulator at N=8, G=4, K=4 (A=12, three chunks).
module tb_csa_accumulator;
  import csa_pkg::*;

  localparam int N = 8;
  localparam int G = 4;
  localparam int K = 4;
  localparam int A = 12;

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;
  int     total = 0;
  int     bad = 0;
  logic [A-1:0] exp_q[$];

  csa_accumulator_if #(.N(N), .A(A)) bus();

  csa_accumulator #(.N(N), .G(G), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  task automatic send_beat(input logic [N-1:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic run_batch(input int nops, input logic [N-1:0] d);
    for (int i = 0; i < nops; i++) send_beat(d, (i == nops - 1));
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) lat = -1;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 12'h000) begin bad++; $display("FAIL reset_out_data got=%h want=000", bus.out_data); end
    total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got=%b want=0", bus.out_ovf); end
    total++; if (dbg_state !== ACC) begin bad++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, ACC); end
  endtask

  task automatic test_basic_sum();
    int lat;
    logic [A-1:0] exp;
    exp_q.push_back(12'h2FD);
    run_batch(3, 8'hFF);
    wait_result(lat);
    exp = exp_q.pop_front();
    total++; if (lat != 3) begin bad++; $display("FAIL basic_latency got=%0d want=3", lat); end
    total++; if (bus.out_data !== exp) begin bad++; $display("FAIL basic_data got=%h want=%h", bus.out_data, exp); end
    total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", bus.out_ovf); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_out got=%b want=0", bus.in_ready); end
    handshake();
  endtask

  task automatic test_single();
    int lat;
    logic [A-1:0] exp;
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h05A);
    run_batch(1, 8'h00);
    wait_result(lat);
    exp = exp_q.pop_front();
    total++; if (lat != 3) begin bad++; $display("FAIL single_zero_latency got=%0d want=3", lat); end
    total++; if (bus.out_data !== exp) begin bad++; $display("FAIL single_zero_data got=%h want=%h", bus.out_data, exp); end
    total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL single_zero_ovf got=%b want=0", bus.out_ovf); end
    handshake();
    run_batch(1, 8'h5A);
    wait_result(lat);
    exp = exp_q.pop_front();
    total++; if (bus.out_data !== exp) begin bad++; $display("FAIL single_5a_data got=%h want=%h", bus.out_data, exp); end
    handshake();
  endtask

  task automatic test_capacity();
    int lat;
    logic [A-1:0] exp;
    exp_q.push_back(12'hFF0);
    exp_q.push_back(12'h0EF);
    run_batch(16, 8'hFF);
    wait_result(lat);
    exp = exp_q.pop_front();
    total++; if (bus.out_data !== exp) begin bad++; $display("FAIL cap16_data got=%h want=%h", bus.out_data, exp); end
    total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL cap16_ovf got=%b want=0", bus.out_ovf); end
    handshake();
    run_batch(17, 8'hFF);
    wait_result(lat);
    exp = exp_q.pop_front();
    total++; if (lat != 3) begin bad++; $display("FAIL cap17_latency got=%0d want=3", lat); end
    total++; if (bus.out_data !== exp) begin bad++; $display("FAIL cap17_data got=%h want=%h", bus.out_data, exp); end
    total++; if (bus.out_ovf !== 1'b1) begin bad++; $display("FAIL cap17_ovf got=%b want=1", bus.out_ovf); end
    handshake();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [A-1:0] exp;
    exp_q.push_back(12'h033);
    exp_q.push_back(12'h005);
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b1);
    wait_result(lat);
    exp = exp_q.pop_front();
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = (k % 2 == 0);
      bus.in_data  = 8'h77;
      bus.in_last  = 1'b1;
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", k, bus.out_valid); end
      total++; if (bus.out_data !== exp) begin bad++; $display("FAIL bp_out_data cyc=%0d got=%h want=%h", k, bus.out_data, exp); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", k, bus.in_ready); end
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0;
    handshake();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_post_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_post_out_valid got=%b want=0", bus.out_valid); end
    run_batch(1, 8'h05);
    wait_result(lat);
    exp = exp_q.pop_front();
    total++; if (bus.out_data !== exp) begin bad++; $display("FAIL bp_next_batch got=%h want=%h", bus.out_data, exp); end
    handshake();
  endtask

  task automatic test_gaps();
    int lat;
    logic [A-1:0] exp;
    exp_q.push_back(12'h006);
    send_beat(8'h01, 1'b0);
    bus.in_last = 1'b1;
    @(posedge clk); #1;
    bus.in_last = 1'b0;
    total++; if (dbg_state !== ACC) begin bad++; $display("FAIL gap_stray_last got=%0d want=%0d", dbg_state, ACC); end
    send_beat(8'h02, 1'b0);
    @(posedge clk); #1;
    send_beat(8'h03, 1'b1);
    wait_result(lat);
    exp = exp_q.pop_front();
    total++; if (lat != 3) begin bad++; $display("FAIL gap_latency got=%0d want=3", lat); end
    total++; if (bus.out_data !== exp) begin bad++; $display("FAIL gap_data got=%h want=%h", bus.out_data, exp); end
    handshake();
  endtask

  task automatic test_reset_mid_resolve();
    int lat;
    logic seen;
    logic [A-1:0] exp;
    exp_q.push_back(12'h010);
    send_beat(8'h33, 1'b1);
    @(posedge clk); #1;
    total++; if (dbg_state !== RESOLVE) begin bad++; $display("FAIL mid_state got=%0d want=%0d", dbg_state, RESOLVE); end
    rst_n = 1'b0;
    #1;
    total++; if (dbg_state !== ACC) begin bad++; $display("FAIL mid_async_state got=%0d want=%0d", dbg_state, ACC); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_lost_batch out_valid_seen=%b want=0", seen); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", bus.in_ready); end
    run_batch(1, 8'h10);
    wait_result(lat);
    exp = exp_q.pop_front();
    total++; if (bus.out_data !== exp) begin bad++; $display("FAIL mid_next_data got=%h want=%h", bus.out_data, exp); end
    total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL mid_next_ovf got=%b want=0", bus.out_ovf); end
    handshake();
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_basic_sum();
    test_single();
    test_capacity();
    test_backpressure();
    test_gaps();
    test_reset_mid_resolve();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
